dcache_port_arbiter: RTL and testbench

- Shares one D$ request port among NR_PORTS requesters: PTW, load unit and store buffer drain.
- Arbitrates request/grant and forwards the tag phase of a granted read to the cache.
- Routes each read response back to the requester that issued it, using an in-order ID FIFO.
- Sits between the LSU-side requesters and the single D$ port.

---
 rtl/ariane_pkg.sv | 38 +++
 rtl/arb_id_fifo.sv | 67 ++++++
 rtl/dcache_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared LSU/D$ request types plus the port map used by dcache_port_arbiter.
package ariane_pkg;

    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;

    typedef enum logic [3:0] {
        AMO_NONE = 4'b0000,
        AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
        AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU, AMO_CAS1, AMO_CAS2
    } amo_t;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        amo_t                          amo_op;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

    // Requesters sharing one D$ port, in default round-robin order.
    localparam int unsigned DCACHE_ARB_PORTS = 3;
    localparam int unsigned PTW_PORT         = 0;
    localparam int unsigned LOAD_PORT        = 1;
    localparam int unsigned STORE_PORT       = 2;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester ids for reads awaiting data_rvalid.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// A push is accepted when full only if a pop happens in the same cycle.
module arb_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign head_o  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one D$ request port among NR_PORTS requesters (PTW, load, store).
// Round-robin by default; define DCACHE_ARB_FIXED_PRIO_EN for fixed
// priority (lowest index wins). Read responses are routed back in order
// through an id FIFO.
module dcache_port_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned NR_PORTS        = DCACHE_ARB_PORTS,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  dcache_req_i_t req_ports_i [NR_PORTS],
    output dcache_req_o_t req_ports_o [NR_PORTS],
    output dcache_req_i_t dcache_req_o,
    input  dcache_req_o_t dcache_req_i
);
    localparam int unsigned IDW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    typedef logic [IDW-1:0] port_id_t;

    logic                lock_q, lock_d;
    port_id_t            lock_id_q, lock_id_d;
    logic                tag_own_valid_q, tag_own_valid_d;
    port_id_t            tag_own_q, tag_own_d;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
    port_id_t            rr_q, rr_d;
    int unsigned         cand;
`endif
    logic [NR_PORTS-1:0] eligible;
    logic                sel_valid, handshake;
    port_id_t            sel_id;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    port_id_t            fifo_head;

    assign fifo_pop  = dcache_req_i.data_rvalid & ~fifo_empty;
    assign handshake = sel_valid & dcache_req_i.data_gnt;
    assign fifo_push = handshake & ~req_ports_i[sel_id].data_we;

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (sel_id),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Reads are held back while the FIFO is full unless a slot frees this cycle.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            eligible[i] = req_ports_i[i].data_req
                        & (req_ports_i[i].data_we | ~fifo_full | fifo_pop);
        end
    end

    // Winner selection: a locked port keeps the bus until granted.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
        cand      = 0;
`endif
        if (lock_q) begin
            sel_id    = lock_id_q;
            sel_valid = req_ports_i[lock_id_q].data_req;
        end else begin
`ifdef DCACHE_ARB_FIXED_PRIO_EN
            for (int unsigned i = 0; i < NR_PORTS; i++) begin
                if (eligible[i] && !sel_valid) begin
                    sel_valid = 1'b1;
                    sel_id    = port_id_t'(i);
                end
            end
`else
            for (int unsigned k = 0; k < NR_PORTS; k++) begin
                cand = (32'(rr_q) + k) % NR_PORTS;
                if (eligible[cand] && !sel_valid) begin
                    sel_valid = 1'b1;
                    sel_id    = port_id_t'(cand);
                end
            end
`endif
        end
        // Nothing is presented to the cache while reset is held.
        sel_valid = sel_valid & ~rst_i;
    end

    // Request mux; tag phase follows the previous cycle's read winner if any.
    always_comb begin
        dcache_req_o = '0;
        if (sel_valid) begin
            dcache_req_o          = req_ports_i[sel_id];
            dcache_req_o.data_req = 1'b1;
        end
        if (tag_own_valid_q) begin
            dcache_req_o.address_tag = req_ports_i[tag_own_q].address_tag;
            dcache_req_o.tag_valid   = req_ports_i[tag_own_q].tag_valid;
            dcache_req_o.kill_req    = req_ports_i[tag_own_q].kill_req;
        end
    end

    // Grant to the winner only; rvalid to the FIFO head only; rdata broadcast.
    always_comb begin
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            req_ports_o[i].data_gnt    = handshake & (sel_id == port_id_t'(i));
            req_ports_o[i].data_rvalid = fifo_pop & (fifo_head == port_id_t'(i));
            req_ports_o[i].data_rdata  = rst_i ? '0 : dcache_req_i.data_rdata;
        end
    end

    // Next-state for lock, tag-phase owner and round-robin pointer.
    always_comb begin
        lock_d          = sel_valid & ~dcache_req_i.data_gnt;
        lock_id_d       = sel_id;
        tag_own_valid_d = fifo_push;
        tag_own_d       = sel_id;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
        rr_d = rr_q;
        if (handshake) begin
            rr_d = (sel_id == port_id_t'(NR_PORTS-1)) ? '0 : sel_id + port_id_t'(1);
        end
`endif
    end

    // Arbiter state registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q          <= 1'b0;
            lock_id_q       <= '0;
            tag_own_valid_q <= 1'b0;
            tag_own_q       <= '0;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
            rr_q            <= '0;
`endif
        end else begin
            lock_q          <= lock_d;
            lock_id_q       <= lock_id_d;
            tag_own_valid_q <= tag_own_valid_d;
            tag_own_q       <= tag_own_d;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
            rr_q            <= rr_d;
`endif
        end
    end

`ifndef SYNTHESIS
    // A response with no outstanding read has no owner and is dropped.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(dcache_req_i.data_rvalid && fifo_empty))
            else $warning("dcache_port_arbiter: data_rvalid with no outstanding read, response dropped");
        end
    end
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: a queue-based reference model
// predicts each cycle's cache-side and requester-side outputs; a monitor
// compares them against the DUT.
`timescale 1ns/1ps
module tb_dcache_port_arbiter;
    import ariane_pkg::*;

    localparam int NP   = 3;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    dcache_req_i_t req_i [NP];
    dcache_req_o_t req_o [NP];
    dcache_req_i_t dc_o;
    dcache_req_o_t dc_i;

    dcache_port_arbiter #(
        .NR_PORTS        (NP),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_ports_i  (req_i),
        .req_ports_o  (req_o),
        .dcache_req_o (dc_o),
        .dcache_req_i (dc_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          req;
        logic [11:0] idx;
        bit          we;
        logic [63:0] wdata;
        logic [2:0]  gnt;
        logic [2:0]  rv;
        logic [63:0] rdata;
        logic [43:0] tag;
        bit          tv;
        bit          kill;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state
    int   m_rr, m_lock_id, m_own;
    bit   m_lock, m_own_v;
    int   idq[$];
    bit   hold_req = 1'b0;
    bit   log_en   = 1'b0;
    int   gnt_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_lock = 1'b0; m_lock_id = 0; m_own_v = 1'b0; m_own = 0;
        idq.delete();
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < NP; p++) req_i[p] = '0;
        dc_i = '0;
    endtask

    task automatic set_req(input int p, input bit we, input logic [43:0] tag);
        req_i[p].data_req      = 1'b1;
        req_i[p].data_we       = we;
        req_i[p].address_index = 12'($urandom);
        req_i[p].data_wdata    = {$urandom, $urandom};
        req_i[p].data_be       = 8'($urandom);
        req_i[p].data_size     = 2'($urandom);
        req_i[p].amo_op        = amo_t'(4'($urandom_range(0, 13)));
        req_i[p].address_tag   = tag;
        req_i[p].tag_valid     = 1'($urandom_range(0, 1));
        req_i[p].kill_req      = 1'b0;
    endtask

    // One clock: predict outputs from the arbitration rules, then advance the model.
    task automatic step();
        exp_t e;
        int   sel;
        bit   sv, pop, hs, is_read;
        int   idx;
        @(negedge clk);
        cyc++;
        pop = dc_i.data_rvalid && (idq.size() > 0);
        sv  = 1'b0;
        sel = 0;
        if (m_lock) begin
            sel = m_lock_id;
            sv  = req_i[sel].data_req;
        end else begin
            for (int k = 0; k < NP; k++) begin
`ifdef DCACHE_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (m_rr + k) % NP;
`endif
                if (!sv && req_i[idx].data_req &&
                    (req_i[idx].data_we || idq.size() < MAXO || pop)) begin
                    sv  = 1'b1;
                    sel = idx;
                end
            end
        end
        hs      = sv && dc_i.data_gnt;
        is_read = !req_i[sel].data_we;
        e.cyc   = cyc;
        e.req   = sv;
        e.idx   = sv ? req_i[sel].address_index : '0;
        e.we    = sv ? req_i[sel].data_we : 1'b0;
        e.wdata = sv ? req_i[sel].data_wdata : '0;
        e.gnt   = hs ? 3'(1 << sel) : 3'b000;
        e.rv    = pop ? 3'(1 << idq[0]) : 3'b000;
        e.rdata = dc_i.data_rdata;
        if (m_own_v) begin
            e.tag = req_i[m_own].address_tag; e.tv = req_i[m_own].tag_valid; e.kill = req_i[m_own].kill_req;
        end else if (sv) begin
            e.tag = req_i[sel].address_tag;   e.tv = req_i[sel].tag_valid;   e.kill = req_i[sel].kill_req;
        end else begin
            e.tag = '0; e.tv = 1'b0; e.kill = 1'b0;
        end
        if (e.req || e.rv != 0 || e.tv) exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (pop) void'(idq.pop_front());
        if (hs && is_read) idq.push_back(sel);
        if (hs) m_rr = (sel + 1) % NP;
        m_lock    = sv && !dc_i.data_gnt;
        m_lock_id = sel;
        m_own_v   = hs && is_read;
        m_own     = sel;
        if (hs && !hold_req) req_i[sel].data_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops one expectation whenever the DUT presents an output.
    initial begin
        exp_t       e;
        logic [2:0] gv, rvv;
        bit         active;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int p = 0; p < NP; p++) begin
                    gv[p]  = req_o[p].data_gnt;
                    rvv[p] = req_o[p].data_rvalid;
                end
                active = dc_o.data_req || dc_o.tag_valid || gv != 0 || rvv != 0;
                if (active) begin
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_output (cycle %0d): got req=%0b gnt=%b rvalid=%b tag_valid=%0b expected none",
                                 cyc, dc_o.data_req, gv, rvv, dc_o.tag_valid);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_req", 64'(dc_o.data_req), 64'(e.req));
                        if (e.req) begin
                            chk("address_index", 64'(dc_o.address_index), 64'(e.idx));
                            chk("data_we", 64'(dc_o.data_we), 64'(e.we));
                            chk("data_wdata", dc_o.data_wdata, e.wdata);
                        end
                        chk("port_gnt", 64'(gv), 64'(e.gnt));
                        chk("port_rvalid", 64'(rvv), 64'(e.rv));
                        if (e.rv != 0) begin
                            for (int p = 0; p < NP; p++) chk("port_rdata", req_o[p].data_rdata, e.rdata);
                        end
                        chk("address_tag", 64'(dc_o.address_tag), 64'(e.tag));
                        chk("tag_valid", 64'(dc_o.tag_valid), 64'(e.tv));
                        chk("kill_req", 64'(dc_o.kill_req), 64'(e.kill));
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    n_checks++; n_fail++;
                    $display("FAIL missing_output (cycle %0d): got no output expected req=%0b gnt=%b rvalid=%b",
                             cyc, e.req, e.gnt, e.rv);
                end
                if (log_en && gv != 0) gnt_log.push_back(gv[0] ? 0 : (gv[1] ? 1 : 2));
            end
        end
    end

    initial begin
        int exp_order[$];
        clear_inputs();
        model_reset();

        // Reset state with busy inputs: everything must stay quiet.
        set_req(0, 1'b0, 44'h1);
        set_req(2, 1'b1, 44'h2);
        req_i[0].tag_valid = 1'b1;
        req_i[0].kill_req  = 1'b1;
        dc_i.data_gnt      = 1'b1;
        dc_i.data_rvalid   = 1'b1;
        dc_i.data_rdata    = 64'hFFFF_0000_1234_5678;
        repeat (3) @(negedge clk);
        #2;
        for (int p = 0; p < NP; p++) begin
            chk("reset_gnt", 64'(req_o[p].data_gnt), 64'd0);
            chk("reset_rvalid", 64'(req_o[p].data_rvalid), 64'd0);
            chk("reset_rdata", req_o[p].data_rdata, 64'd0);
        end
        chk("reset_data_req", 64'(dc_o.data_req), 64'd0);
        chk("reset_tag_valid", 64'(dc_o.tag_valid), 64'd0);
        chk("reset_kill_req", 64'(dc_o.kill_req), 64'd0);
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single store on port 2, granted on the first request cycle.
        set_req(2, 1'b1, 44'h55);
        dc_i.data_gnt = 1'b1;
        step();
        clear_inputs();

        // Fairness: all three request continuously with grant held high.
        log_en = 1'b1; hold_req = 1'b1;
        for (int p = 0; p < NP; p++) set_req(p, 1'b1, 44'(p));
        dc_i.data_gnt = 1'b1;
        repeat (6) step();
        log_en = 1'b0; hold_req = 1'b0;
        clear_inputs();
`ifdef DCACHE_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 0, 1, 2};
`endif
        chk("fair_grant_count", 64'(gnt_log.size()), 64'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < gnt_log.size(); i++)
            chk("fair_grant_order", 64'(gnt_log[i]), 64'(exp_order[i]));
        gnt_log.delete();

        // Lock: port 1 read stalls 3 cycles, port 0 joins in cycle 2.
        log_en = 1'b1;
        set_req(1, 1'b0, 44'h111);
        step();
        set_req(0, 1'b1, 44'h222);
        step();
        step();
        dc_i.data_gnt = 1'b1;
        step();
        step();
        log_en = 1'b0;
        dc_i.data_gnt = 1'b0;
        chk("lock_grant_count", 64'(gnt_log.size()), 64'd2);
        if (gnt_log.size() == 2) begin
            chk("lock_first_grant", 64'(gnt_log[0]), 64'd1);
            chk("lock_second_grant", 64'(gnt_log[1]), 64'd0);
        end
        gnt_log.delete();
        dc_i.data_rvalid = 1'b1; dc_i.data_rdata = 64'h77;
        step();
        clear_inputs();

        // Tag phase and routing: port 1 read at T, tag 0xABC at T+1, data at T+3.
        set_req(1, 1'b0, 44'h123);
        dc_i.data_gnt = 1'b1;
        step();
        dc_i.data_gnt = 1'b0;
        req_i[1].address_tag = 44'hABC;
        req_i[1].tag_valid   = 1'b1;
        step();
        req_i[1].tag_valid = 1'b0;
        step();
        dc_i.data_rvalid = 1'b1; dc_i.data_rdata = 64'hDEAD;
        step();
        clear_inputs();

        // FIFO full: two reads outstanding, third read waits for the first rvalid.
        set_req(0, 1'b0, 44'h10);
        set_req(1, 1'b0, 44'h11);
        dc_i.data_gnt = 1'b1;
        step();
        step();
        set_req(2, 1'b0, 44'h12);
        step();
        dc_i.data_rvalid = 1'b1; dc_i.data_rdata = 64'hA0;
        step();
        dc_i.data_rdata = 64'hA1;
        step();
        dc_i.data_rdata = 64'hA2;
        step();
        clear_inputs();

        // Reset mid-operation with two reads outstanding; late response is dropped.
        set_req(0, 1'b0, 44'h20);
        set_req(1, 1'b0, 44'h21);
        dc_i.data_gnt = 1'b1;
        step();
        step();
        do_reset();
        dc_i.data_rvalid = 1'b1; dc_i.data_rdata = 64'hBAD;
        step();
        dc_i.data_rvalid = 1'b0;
        set_req(2, 1'b1, 44'h30);
        dc_i.data_gnt = 1'b1;
        step();
        clear_inputs();

        // Randomized traffic; requests are held until granted.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!req_i[p].data_req && $urandom_range(0, 2) == 0)
                    set_req(p, 1'($urandom_range(0, 1)), 44'({$urandom, $urandom}));
                req_i[p].address_tag = 44'({$urandom, $urandom});
                req_i[p].tag_valid   = 1'($urandom_range(0, 1));
                req_i[p].kill_req    = 1'($urandom_range(0, 1));
            end
            dc_i.data_gnt    = ($urandom_range(0, 3) != 0);
            dc_i.data_rvalid = (idq.size() > 0) && ($urandom_range(0, 1) == 1);
            dc_i.data_rdata  = {$urandom, $urandom};
            step();
        end

        clear_inputs();
        step();
        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
